// File: rtl/rv_pkg.sv
// Shared RISC-V decode helpers for the fetch queue: opcode constants,
// default address width and sign-extended immediate extraction.
package rv_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam int         AW_DEF     = 10;

    // J-type immediate, sign-extended byte offset (bit 0 always zero)
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended byte offset (bit 0 always zero)
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular FIFO storage for the fetch queue: DEPTH entries of W bits,
// read/write pointers, occupancy count, full/empty. clr empties it
// synchronously and takes priority over push/pop.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 42,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;
    assign rdata = mem_q[rptr_q];

    // Next pointer and count values; clear wins, pointers wrap mod DEPTH
    always_comb begin
        do_push_s = push & ~clr;
        do_pop_s  = pop & ~empty & ~clr;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (clr) begin
            wptr_d  = {PW{1'b0}};
            rptr_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_d = wptr_q + PW'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (do_pop_s) begin
                rptr_d = rptr_q + PW'(1);
            end else begin
                rptr_d = rptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wptr_q] <= wdata;
        end else begin
            mem_q[wptr_q] <= mem_q[wptr_q];
        end
    end

endmodule

// File: rtl/fetch_queue_redirect.sv
// Fetch-side instruction queue with JAL redirect and wrong-path squash.
// Optional static backward-taken branch prediction: FQ_BTFN_PREDICT_EN.
module fetch_queue_redirect
    import rv_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int AW     = AW_DEF,
    parameter int SQUASH = 2
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          f_valid,
    input  logic [31:0]   f_instr,
    input  logic [AW-1:0] f_addr,
    input  logic          flush,
    output logic          Branch,
    output logic [AW-1:0] TargetAddress,
    output logic          d_valid,
    input  logic          d_ready,
    output logic [31:0]   d_instr,
    output logic [AW-1:0] d_addr,
`ifdef FQ_BTFN_PREDICT_EN
    output logic          d_pred,
`endif
    output logic          full,
    output logic          overflow
);

`ifdef FQ_BTFN_PREDICT_EN
    localparam int W = 32 + AW + 1;
`else
    localparam int W = 32 + AW;
`endif
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int SQW = (SQUASH < 1) ? 1 : $clog2(SQUASH + 1);

    logic [SQW-1:0] sq_cnt_q, sq_cnt_d;
    logic           branch_q, branch_d;
    logic [AW-1:0]  target_q, target_d;
    logic           overflow_q, overflow_d;

    logic           pop_s;
    logic           push_ok_s;
    logic           redirect_s;
    logic           pred_s;
    logic [31:0]    offset_s;
    logic [31:0]    target_full_s;
    logic [W-1:0]   wdata_s;
    logic [W-1:0]   rdata_s;
    logic [CW-1:0]  count_s;
    logic           full_s;
    logic           empty_s;
    logic           unused_s;

    fq_fifo #(.DEPTH(DEPTH), .W(W), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst_n (Reset),
        .clr   (flush),
        .push  (push_ok_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign d_valid  = ~empty_s;
    assign d_instr  = rdata_s[31:0];
    assign d_addr   = rdata_s[32 +: AW];
    assign full     = full_s;
    assign overflow = overflow_q;
    assign Branch        = branch_q;
    assign TargetAddress = target_q;
`ifdef FQ_BTFN_PREDICT_EN
    assign d_pred   = rdata_s[W-1];
    assign wdata_s  = {pred_s, f_addr, f_instr};
`else
    assign wdata_s  = {f_addr, f_instr};
`endif
    assign unused_s = ^{count_s, target_full_s};

    // Accept/drop decision, redirect detection and next-state for the
    // squash counter, redirect pulse and sticky overflow
    always_comb begin
        pop_s         = d_valid & d_ready;
        push_ok_s     = f_valid & (sq_cnt_q == {SQW{1'b0}}) & (~full_s | pop_s) & ~flush;
        pred_s        = 1'b0;
        offset_s      = 32'd0;
        if (f_instr[6:0] == OPC_JAL) begin
            pred_s   = 1'b1;
            offset_s = imm_j(f_instr);
`ifdef FQ_BTFN_PREDICT_EN
        end else if ((f_instr[6:0] == OPC_BRANCH) && f_instr[31]) begin
            pred_s   = 1'b1;
            offset_s = imm_b(f_instr);
`endif
        end else begin
            pred_s   = 1'b0;
            offset_s = 32'd0;
        end
        // Word-address step is the byte offset divided by four
        target_full_s = {{(32-AW){1'b0}}, f_addr} + {{2{offset_s[31]}}, offset_s[31:2]};
        redirect_s    = push_ok_s & pred_s;

        branch_d   = redirect_s;
        target_d   = redirect_s ? target_full_s[AW-1:0] : target_q;
        overflow_d = overflow_q |
                     (f_valid & (sq_cnt_q == {SQW{1'b0}}) & full_s & ~pop_s & ~flush);
        if (flush || redirect_s) begin
            sq_cnt_d = SQW'(SQUASH);
        end else if (sq_cnt_q != {SQW{1'b0}}) begin
            sq_cnt_d = sq_cnt_q - SQW'(1);
        end else begin
            sq_cnt_d = {SQW{1'b0}};
        end
    end

    // Redirect, squash and overflow registers
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sq_cnt_q   <= {SQW{1'b0}};
            branch_q   <= 1'b0;
            target_q   <= {AW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            sq_cnt_q   <= sq_cnt_d;
            branch_q   <= branch_d;
            target_q   <= target_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue_redirect.sv
// Directed self-checking bench for fetch_queue_redirect (default DEPTH=4,
// AW=10, SQUASH=2). Expected values are hand-computed constants.
module tb_fetch_queue_redirect;

    localparam int AW = 10;
    localparam logic [31:0] ADDI   = 32'h0000_0013;
    localparam logic [31:0] JAL_P8 = 32'h0080_006F;
    localparam logic [31:0] JAL_M4 = 32'hFFDF_F06F;

    logic          clk = 1'b0;
    logic          Reset = 1'b0;
    logic          f_valid = 1'b0;
    logic [31:0]   f_instr = 32'd0;
    logic [AW-1:0] f_addr = '0;
    logic          flush = 1'b0;
    logic          Branch;
    logic [AW-1:0] TargetAddress;
    logic          d_valid;
    logic          d_ready = 1'b0;
    logic [31:0]   d_instr;
    logic [AW-1:0] d_addr;
    logic          full;
    logic          overflow;
`ifdef FQ_BTFN_PREDICT_EN
    logic          d_pred;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue_redirect dut (
        .clk           (clk),
        .Reset         (Reset),
        .f_valid       (f_valid),
        .f_instr       (f_instr),
        .f_addr        (f_addr),
        .flush         (flush),
        .Branch        (Branch),
        .TargetAddress (TargetAddress),
        .d_valid       (d_valid),
        .d_ready       (d_ready),
        .d_instr       (d_instr),
        .d_addr        (d_addr),
`ifdef FQ_BTFN_PREDICT_EN
        .d_pred        (d_pred),
`endif
        .full          (full),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; leaves time 1 unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [AW-1:0] a);
        f_valid = v;
        f_instr = ins;
        f_addr  = a;
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_dvalid", 32'(d_valid), 32'd0);
        chk("rst_branch", 32'(Branch), 32'd0);
        chk("rst_target", 32'(TargetAddress), 32'd0);
        chk("rst_dinstr", d_instr, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        Reset = 1'b1;
        tick();

        // fill, overflow, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ADDI, AW'(i));
            tick();
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_head", 32'(d_addr), 32'h000);
        drive(1'b1, ADDI, 10'h004);
        tick();
        chk("ovf_set", 32'(overflow), 32'd1);
        drive(1'b0, 32'd0, 10'h000);
        d_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", 32'(d_addr), 32'(i));
            chk("drain_instr", d_instr, ADDI);
            tick();
        end
        chk("drain_empty", 32'(d_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        d_ready = 1'b0;

        // asynchronous reset mid-stream with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADDI, AW'(8 + i));
            tick();
        end
        drive(1'b0, 32'd0, 10'h000);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_dvalid", 32'(d_valid), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_branch", 32'(Branch), 32'd0);
        chk("arst_daddr", 32'(d_addr), 32'd0);
        tick();
        Reset = 1'b1;
        tick();

        // JAL +8 at 0x010: redirect to 0x012, squash two words
        drive(1'b1, JAL_P8, 10'h010);
        tick();
        chk("jal_branch", 32'(Branch), 32'd1);
        chk("jal_target", 32'(TargetAddress), 32'h012);
        drive(1'b1, ADDI, 10'h011);
        tick();
        chk("jal_pulse1", 32'(Branch), 32'd0);
        drive(1'b1, ADDI, 10'h012);
        tick();
        drive(1'b1, ADDI, 10'h013);
        tick();
        drive(1'b0, 32'd0, 10'h000);
        d_ready = 1'b1;
        chk("jal_q0_addr", 32'(d_addr), 32'h010);
        chk("jal_q0_instr", d_instr, JAL_P8);
        tick();
        chk("jal_q1_addr", 32'(d_addr), 32'h013);
        tick();
        chk("jal_q_empty", 32'(d_valid), 32'd0);
        d_ready = 1'b0;

        // JAL -4 at 0x000 wraps to 0x3FF
        drive(1'b1, JAL_M4, 10'h000);
        tick();
        chk("jalm4_branch", 32'(Branch), 32'd1);
        chk("jalm4_target", 32'(TargetAddress), 32'h3FF);
        drive(1'b0, 32'd0, 10'h000);
        d_ready = 1'b1;
        tick();
        tick();
        d_ready = 1'b0;
        chk("jalm4_drained", 32'(d_valid), 32'd0);

        // flush with 3 queued and a JAL at the input
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADDI, AW'(32 + i));
            tick();
        end
        chk("pre_flush_head", 32'(d_addr), 32'h020);
        flush = 1'b1;
        drive(1'b1, JAL_P8, 10'h030);
        tick();
        flush = 1'b0;
        chk("flush_dvalid", 32'(d_valid), 32'd0);
        chk("flush_branch", 32'(Branch), 32'd0);
        drive(1'b1, ADDI, 10'h031);
        tick();
        chk("flush_sq1", 32'(d_valid), 32'd0);
        drive(1'b1, ADDI, 10'h032);
        tick();
        chk("flush_sq2", 32'(d_valid), 32'd0);
        drive(1'b1, ADDI, 10'h033);
        tick();
        drive(1'b0, 32'd0, 10'h000);
        chk("flush_after", 32'(d_addr), 32'h033);
        chk("flush_nobr", 32'(Branch), 32'd0);
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;

        // full queue with simultaneous pop accepts the push
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ADDI, AW'(64 + i));
            tick();
        end
        chk("fp_full", 32'(full), 32'd1);
        d_ready = 1'b1;
        drive(1'b1, ADDI, 10'h044);
        tick();
        drive(1'b0, 32'd0, 10'h000);
        d_ready = 1'b0;
        chk("fp_still_full", 32'(full), 32'd1);
        chk("fp_no_ovf", 32'(overflow), 32'd0);
        d_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fp_order", 32'(d_addr), 32'(65 + i));
            tick();
        end
        chk("fp_empty", 32'(d_valid), 32'd0);
        d_ready = 1'b0;

`ifdef FQ_BTFN_PREDICT_EN
        // backward branch (imm = -8) at 0x020 predicted taken
        drive(1'b1, 32'hFE00_0CE3, 10'h020);
        tick();
        drive(1'b0, 32'd0, 10'h000);
        chk("bt_branch", 32'(Branch), 32'd1);
        chk("bt_target", 32'(TargetAddress), 32'h01E);
        chk("bt_pred", 32'(d_pred), 32'd1);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
